// File: rtl/ac97_pkg.sv
// Shared AC-link constants: frame/slot geometry, tag bit positions, and
// the receive FSM encoding. Also used by the command/PCM transmitter.
package ac97_pkg;

  localparam int FRAME_BITS = 256;
  localparam int SLOT0_BITS = 16;
  localparam int SLOT_BITS  = 20;

  localparam int TAG_READY = 15;
  localparam int TAG_SLOT1 = 14;
  localparam int TAG_SLOT2 = 13;
  localparam int TAG_SLOT3 = 12;
  localparam int TAG_SLOT4 = 11;

  // Frame bit index of the first bit of slot n (n >= 1).
  function automatic int slot_first(input int n);
    return SLOT0_BITS + SLOT_BITS * (n - 1);
  endfunction

  // Frame bit index of the final (LSB) bit of slot n (n >= 1).
  function automatic logic [7:0] slot_last(input int n);
    return 8'(slot_first(n) + SLOT_BITS - 1);
  endfunction

  localparam logic [7:0] TAG_LAST   = 8'(SLOT0_BITS - 1);
  localparam logic [7:0] SLOT1_LAST = slot_last(1);
  localparam logic [7:0] SLOT2_LAST = slot_last(2);
  localparam logic [7:0] SLOT3_LAST = slot_last(3);
  localparam logic [7:0] SLOT4_LAST = slot_last(4);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RX   = 1'b1
  } rx_state_e;

endpackage

// File: rtl/ac97_frame_rx.sv
// AC-link receiver: deserialises SDATA_IN framed by SYNC, publishes tag,
// status readback and capture PCM. Optional AC97_RX_ERRCNT_EN adds err_count.
module ac97_frame_rx
  import ac97_pkg::*;
#(
  parameter int SAMPLE_W = 20
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                sync,
  input  logic                sdata_in,
  output logic                ready,
  output logic                codec_ready,
  output logic                status_valid,
  output logic [7:0]          status_address,
  output logic [15:0]         status_data,
  output logic                sample_valid,
  output logic [SAMPLE_W-1:0] left_in,
  output logic [SAMPLE_W-1:0] right_in,
  output logic                frame_err
`ifdef AC97_RX_ERRCNT_EN
  ,
  output logic [7:0]          err_count
`endif
);

  // Handshake: ready, status_valid, sample_valid and frame_err are single-cycle
  // strobes with no back-pressure; data outputs stay stable between publishes.

  rx_state_e             state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  sync_prev_q, sync_prev_d;
  logic [SLOT_BITS-1:0]  shift_q, shift_d;
  logic [15:0]           tag_q, tag_d;
  logic [SLOT_BITS-1:0]  slot1_q, slot1_d;
  logic [SLOT_BITS-1:0]  slot2_q, slot2_d;
  logic [SLOT_BITS-1:0]  slot3_q, slot3_d;
  logic [SLOT_BITS-1:0]  slot4_q, slot4_d;

  logic                  ready_q, ready_d;
  logic                  codec_ready_q, codec_ready_d;
  logic                  status_valid_q, status_valid_d;
  logic [7:0]            status_address_q, status_address_d;
  logic [15:0]           status_data_q, status_data_d;
  logic                  sample_valid_q, sample_valid_d;
  logic [SAMPLE_W-1:0]   left_q, left_d;
  logic [SAMPLE_W-1:0]   right_q, right_d;
  logic                  frame_err_q, frame_err_d;
`ifdef AC97_RX_ERRCNT_EN
  logic [7:0]            err_cnt_q, err_cnt_d;
`endif

  logic                  sync_rise;
  logic [SLOT_BITS-1:0]  shift_in;
  logic                  publish;
  logic                  lost_align;

  assign sync_rise = sync & ~sync_prev_q;
  assign shift_in  = {shift_q[SLOT_BITS-2:0], sdata_in};

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    sync_prev_d      = sync;
    shift_d          = shift_in;
    tag_d            = tag_q;
    slot1_d          = slot1_q;
    slot2_d          = slot2_q;
    slot3_d          = slot3_q;
    slot4_d          = slot4_q;
    ready_d          = 1'b0;
    codec_ready_d    = codec_ready_q;
    status_valid_d   = 1'b0;
    status_address_d = status_address_q;
    status_data_d    = status_data_q;
    sample_valid_d   = 1'b0;
    left_d           = left_q;
    right_d          = right_q;
    frame_err_d      = 1'b0;
    publish          = 1'b0;
    lost_align       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sync_rise) begin
          state_d = ST_RX;
          cnt_d   = 8'd1;
        end
      end
      ST_RX: begin
        if (cnt_q == 8'd0) begin
          // Counter only wraps to 0 after bit 255, so a frame is complete here.
          publish = 1'b1;
          if (sync_rise) begin
            cnt_d = 8'd1;
          end else begin
            lost_align = 1'b1;
            state_d    = ST_IDLE;
          end
        end else if (sync_rise) begin
          frame_err_d = 1'b1;
          cnt_d       = 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          case (cnt_q)
            TAG_LAST:   tag_d   = shift_in[15:0];
            SLOT1_LAST: slot1_d = shift_in;
            SLOT2_LAST: slot2_d = shift_in;
            SLOT3_LAST: slot3_d = shift_in;
            SLOT4_LAST: slot4_d = shift_in;
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (publish) begin
      ready_d       = 1'b1;
      codec_ready_d = tag_q[TAG_READY];
      if (tag_q[TAG_READY] & tag_q[TAG_SLOT1] & tag_q[TAG_SLOT2]) begin
        status_valid_d   = 1'b1;
        status_address_d = {1'b0, slot1_q[18:12]};
        status_data_d    = slot2_q[19:4];
      end
      if (tag_q[TAG_READY] & tag_q[TAG_SLOT3] & tag_q[TAG_SLOT4]) begin
        sample_valid_d = 1'b1;
        left_d         = slot3_q[SLOT_BITS-1 -: SAMPLE_W];
        right_d        = slot4_q[SLOT_BITS-1 -: SAMPLE_W];
      end
    end

`ifdef AC97_RX_ERRCNT_EN
    err_cnt_d = err_cnt_q;
    if ((frame_err_d | lost_align) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      sync_prev_q      <= 1'b0;
      shift_q          <= '0;
      tag_q            <= '0;
      slot1_q          <= '0;
      slot2_q          <= '0;
      slot3_q          <= '0;
      slot4_q          <= '0;
      ready_q          <= 1'b0;
      codec_ready_q    <= 1'b0;
      status_valid_q   <= 1'b0;
      status_address_q <= '0;
      status_data_q    <= '0;
      sample_valid_q   <= 1'b0;
      left_q           <= '0;
      right_q          <= '0;
      frame_err_q      <= 1'b0;
`ifdef AC97_RX_ERRCNT_EN
      err_cnt_q        <= '0;
`endif
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      sync_prev_q      <= sync_prev_d;
      shift_q          <= shift_d;
      tag_q            <= tag_d;
      slot1_q          <= slot1_d;
      slot2_q          <= slot2_d;
      slot3_q          <= slot3_d;
      slot4_q          <= slot4_d;
      ready_q          <= ready_d;
      codec_ready_q    <= codec_ready_d;
      status_valid_q   <= status_valid_d;
      status_address_q <= status_address_d;
      status_data_q    <= status_data_d;
      sample_valid_q   <= sample_valid_d;
      left_q           <= left_d;
      right_q          <= right_d;
      frame_err_q      <= frame_err_d;
`ifdef AC97_RX_ERRCNT_EN
      err_cnt_q        <= err_cnt_d;
`endif
    end
  end

  assign ready          = ready_q;
  assign codec_ready    = codec_ready_q;
  assign status_valid   = status_valid_q;
  assign status_address = status_address_q;
  assign status_data    = status_data_q;
  assign sample_valid   = sample_valid_q;
  assign left_in        = left_q;
  assign right_in       = right_q;
  assign frame_err      = frame_err_q;
`ifdef AC97_RX_ERRCNT_EN
  assign err_count      = err_cnt_q;
`endif

endmodule

// File: tb/tb_ac97_frame_rx.sv
// Bench for ac97_frame_rx: serial frames built from field values, checked
// against a field-level model of publish behaviour (AC97_RX_ERRCNT_EN aware).
module tb_ac97_frame_rx;

  localparam int SW = 20;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          sync;
  logic          sdata_in;
  logic          ready;
  logic          codec_ready;
  logic          status_valid;
  logic [7:0]    status_address;
  logic [15:0]   status_data;
  logic          sample_valid;
  logic [SW-1:0] left_in;
  logic [SW-1:0] right_in;
  logic          frame_err;
`ifdef AC97_RX_ERRCNT_EN
  logic [7:0]    err_count;
`endif

  ac97_frame_rx #(.SAMPLE_W(SW)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .sync           (sync),
    .sdata_in       (sdata_in),
    .ready          (ready),
    .codec_ready    (codec_ready),
    .status_valid   (status_valid),
    .status_address (status_address),
    .status_data    (status_data),
    .sample_valid   (sample_valid),
    .left_in        (left_in),
    .right_in       (right_in),
    .frame_err      (frame_err)
`ifdef AC97_RX_ERRCNT_EN
    ,
    .err_count      (err_count)
`endif
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: expected output state after the next check point.
  logic          pend;
  logic          e_codec, e_sv, e_pv, e_ferr;
  logic [7:0]    e_addr;
  logic [15:0]   e_data;
  logic [SW-1:0] e_left, e_right;
  int            e_errcnt;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend = 0; e_codec = 0; e_sv = 0; e_pv = 0; e_ferr = 0;
    e_addr = '0; e_data = '0; e_left = '0; e_right = '0; e_errcnt = 0;
  endtask

  // A complete frame has been delivered; it is published at the next edge.
  task automatic model_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                             input logic [19:0] s3, input logic [19:0] s4);
    pend    = 1;
    e_codec = tag[15];
    e_sv    = tag[15] & tag[14] & tag[13];
    e_pv    = tag[15] & tag[12] & tag[11];
    if (e_sv) begin
      e_addr = {1'b0, s1[18:12]};
      e_data = s2[19:4];
    end
    if (e_pv) begin
      e_left  = s3[19 -: SW];
      e_right = s4[19 -: SW];
    end
  endtask

  task automatic bump_err();
    if (e_errcnt < 255) e_errcnt++;
  endtask

  task automatic check_point();
    chk("ready", ready, pend);
    chk("status_valid", status_valid, pend & e_sv);
    chk("sample_valid", sample_valid, pend & e_pv);
    chk("codec_ready", codec_ready, e_codec);
    chk("status_address", status_address, e_addr);
    chk("status_data", status_data, e_data);
    chk("left_in", left_in, e_left);
    chk("right_in", right_in, e_right);
    chk("frame_err", frame_err, e_ferr);
`ifdef AC97_RX_ERRCNT_EN
    chk("err_count", err_count, e_errcnt[7:0]);
`endif
    pend   = 0;
    e_ferr = 0;
  endtask

  // Drive the first nbits bits of a frame; SYNC is high during the tag slot.
  task automatic send(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                      input logic [19:0] s3, input logic [19:0] s4, input int nbits);
    logic [159:0] fill;
    logic [255:0] fr;
    for (int i = 0; i < 5; i++) fill[i*32 +: 32] = $urandom();
    fr = {tag, s1, s2, s3, s4, fill};
    for (int b = 0; b < nbits; b++) begin
      sync     = (b < 16);
      sdata_in = fr[255 - b];
      tick();
      if (b == 0) check_point();
      if (b == 50) begin
        chk("ready_mid", ready, 1'b0);
        chk("frame_err_mid", frame_err, 1'b0);
      end
      if (b == 255) model_frame(tag, s1, s2, s3, s4);
    end
  endtask

  task automatic send_random();
    logic [15:0] tag;
    tag = 16'($urandom());
    send(tag, 20'($urandom()), 20'($urandom()), 20'($urandom()), 20'($urandom()), 256);
  endtask

  // SYNC withheld: the last frame still publishes, then the receiver idles.
  task automatic withhold_sync(input int idle_cycles);
    sync     = 1'b0;
    sdata_in = 1'($urandom());
    tick();
    bump_err();
    check_point();
    for (int i = 0; i < idle_cycles; i++) begin
      sdata_in = 1'($urandom());
      tick();
      chk("ready_idle", ready, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    reset_n  = 1'b0;
    sync     = 1'b0;
    sdata_in = 1'b0;
    repeat (3) tick();
    check_point();
    reset_n = 1'b1;

    send(16'hF800, 20'h26000, 20'h000F0, 20'($urandom()), 20'($urandom()), 256);
    send(16'h9800, 20'h51234, 20'h5678A, 20'hABCDE, 20'h13579, 256);
    send(16'h7800, 20'h7F000, 20'hFFFF0, 20'h11111, 20'h22222, 256);
    for (int i = 0; i < 8; i++) send_random();

    // Misaligned SYNC at b=100: partial frame dropped, next frame clean.
    send(16'hF800, 20'h12000, 20'h34560, 20'h55555, 20'h66666, 100);
    e_ferr = 1;
    bump_err();
    send(16'hF800, 20'h3C000, 20'hBEEF0, 20'h0F0F0, 20'hF0F0F, 256);
    send_random();
    withhold_sync(20);

    // Reset mid-frame at b=60, then a fresh frame.
    send(16'hF800, 20'h7E000, 20'hDEAD0, 20'h12345, 20'h54321, 60);
    reset_n = 1'b0;
    sync    = 1'b0;
    tick();
    reset_n = 1'b1;
    model_reset();
    check_point();
    send(16'hF800, 20'h02000, 20'hCAFE0, 20'h98765, 20'h45678, 256);
    send_random();
    withhold_sync(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
